tty_uart: RTL

//  Parametrised full-duplex UART: TX serialiser + RX deserialiser sharing one baud divisor.

---
 rtl/tty_uart.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tty_uart.sv
// tty_uart: full-duplex UART, TX serialiser and RX deserialiser sharing one
// bit period (CLK_DIV clk cycles), with a small RX FIFO and error pulses.
// Optional parity bit is built in when the macro TTY_PARITY_EN is defined.
module tty_uart #(
   parameter int unsigned CLK_DIV       = 400,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned STOP_BITS     = 1,
   parameter int unsigned RX_FIFO_DEPTH = 4,
   parameter bit          PARITY_ODD    = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx,
   input  logic                 rx,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_busy,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   output logic                 rx_parity_err
);

`ifdef TTY_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   localparam logic [15:0] BIT_RELOAD  = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_RELOAD = 16'(CLK_DIV / 2 - 1);
   localparam logic [3:0]  LAST_DATA   = 4'(DATA_BITS - 1);
   localparam logic [3:0]  LAST_STOP   = 4'(STOP_BITS - 1);
   localparam int unsigned AW          = $clog2(RX_FIFO_DEPTH);
   localparam int unsigned CW          = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

   // ---------------- TX ----------------
   state_e               tx_state_q, tx_state_d;
   logic [15:0]          tx_cnt_q, tx_cnt_d;
   logic [3:0]           tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_q, tx_d;

   // TX next state; the last stop bit hands over to IDLE one cycle early so the
   // line holds 1 for its final cycle while a new byte can already be accepted.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      case (tx_state_q)
         S_IDLE: begin
            if (tx_valid) begin
               tx_state_d = S_START;
               tx_cnt_d   = BIT_RELOAD;
               tx_shift_d = tx_data;
               tx_par_d   = (^tx_data) ^ PARITY_ODD;
            end
         end
         S_STOP: begin
            if (tx_cnt_q == 16'd1 && tx_bit_q == LAST_STOP) begin
               tx_state_d = S_IDLE;
            end else if (tx_cnt_q != '0) begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end else begin
               tx_cnt_d = BIT_RELOAD;
               tx_bit_d = tx_bit_q + 4'd1;
            end
         end
         default: begin
            if (tx_cnt_q != '0) begin
               tx_cnt_d = tx_cnt_q - 16'd1;
            end else begin
               tx_cnt_d = BIT_RELOAD;
               tx_bit_d = '0;
               if (tx_state_q == S_START) begin
                  tx_state_d = S_DATA;
               end else if (tx_state_q == S_DATA) begin
                  tx_shift_d = tx_shift_q >> 1;
                  if (tx_bit_q == LAST_DATA) tx_state_d = PAR_EN ? S_PARITY : S_STOP;
                  else                       tx_bit_d   = tx_bit_q + 4'd1;
               end else begin
                  tx_state_d = S_STOP;
               end
            end
         end
      endcase
      case (tx_state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = tx_shift_d[0];
         S_PARITY: tx_d = tx_par_q;
         default:  tx_d = 1'b1;
      endcase
   end

   // TX registers; the line output is registered to keep the pin glitch-free
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = (tx_state_q == S_IDLE);

   // ---------------- RX ----------------
   logic                 rx_s1_q, rx_s2_q, rx_prev_q;
   state_e               rx_state_q, rx_state_d;
   logic [15:0]          rx_cnt_q, rx_cnt_d;
   logic [3:0]           rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_par_q, rx_par_d;
   logic                 push, ferr_d, perr_d, ovr_d;
   logic                 ferr_q, perr_q, ovr_q;

   // RX next state: start detect, mid-bit sampling, stop/parity verdict
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      push       = 1'b0;
      ferr_d     = 1'b0;
      perr_d     = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = S_START;
               rx_cnt_d   = HALF_RELOAD;
            end
         end
         default: begin
            if (rx_cnt_q != '0) begin
               rx_cnt_d = rx_cnt_q - 16'd1;
            end else begin
               rx_cnt_d = BIT_RELOAD;
               rx_bit_d = '0;
               case (rx_state_q)
                  S_START: rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
                  S_DATA: begin
                     rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                     if (rx_bit_q == LAST_DATA) rx_state_d = PAR_EN ? S_PARITY : S_STOP;
                     else                       rx_bit_d   = rx_bit_q + 4'd1;
                  end
                  S_PARITY: begin
                     rx_par_d   = rx_s2_q;
                     rx_state_d = S_STOP;
                  end
                  default: begin
                     rx_state_d = S_IDLE;
                     if (!rx_s2_q)                                               ferr_d = 1'b1;
                     else if (PAR_EN && (rx_par_q != ((^rx_shift_q) ^ PARITY_ODD))) perr_d = 1'b1;
                     else                                                        push   = 1'b1;
                  end
               endcase
            end
         end
      endcase
   end

   // RX synchroniser, FSM registers and registered error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         ferr_q     <= 1'b0;
         perr_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         rx_s1_q    <= rx;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         ferr_q     <= ferr_d;
         perr_q     <= perr_d;
         ovr_q      <= ovr_d;
      end
   end

   assign rx_busy       = (rx_state_q != S_IDLE);
   assign rx_frame_err  = ferr_q;
   assign rx_parity_err = perr_q;
   assign rx_overrun    = ovr_q;

   // ---------------- RX FIFO ----------------
   logic [DATA_BITS-1:0] mem_q [RX_FIFO_DEPTH];
   logic [AW-1:0]        wptr_q, rptr_q;
   logic [CW-1:0]        count_q;
   logic                 full, pop, push_ok;

   assign full     = (count_q == CW'(RX_FIFO_DEPTH));
   assign rx_valid = (count_q != '0);
   assign pop      = rx_valid && rx_ready;
   assign push_ok  = push && (!full || pop);
   assign ovr_d    = push && full && !pop;
   assign rx_data  = mem_q[rptr_q];

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= rx_shift_q;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + AW'(1);
         if (pop)     rptr_q <= rptr_q + AW'(1);
         if (push_ok && !pop)      count_q <= count_q + CW'(1);
         else if (!push_ok && pop) count_q <= count_q - CW'(1);
      end
   end

endmodule
